trap_redirect_unit: RTL and testbench
=====================================

// Module: trap_redirect_unit
// PURPOSE
//  Consumer side of the CSR/exception interface.
//  - Takes the exception-initiate strobe, the trap vector (mtvec) and the return PC (mepc) from the CSR/EHU.
//  - Takes the committed-MRET indication from the XB stage.
//  - Sequences the pipeline response: one-cycle PC redirect, then a counted flush of the FD/XB stages.
//  - Tracks whether the core is executing inside a trap handler.
//  Sits between the CSR/EHU and the PC/fetch logic in the 2-stage pipeline.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush stays high after a redirect; legal range 1..15
//  CNT_W         32  width of trap_count (only used with TRAP_CNT_EN)
// PORTS
//  clk                 in   1   single clock, rising edge
//  reset               in   1   synchronous, active-high reset
//  initiate_exception  in   1   CSR/EHU trap request; already qualified by ~XB_bubble
//  XB_mret             in   1   MRET in the XB stage
//  XB_bubble           in   1   XB stage holds no instruction
//  csr_mtvec           in   32  trap vector base (direct mode)
//  csr_mepc            in   32  exception return PC
//  pc_redirect         out  1   one-cycle strobe: load pc_target into the PC
//  pc_target           out  32  redirect target; bits[1:0] always 0
//  flush               out  1   squash FD and XB contents (force bubbles)
//  busy                out  1   FSM is not in RUN
//  in_handler          out  1   a trap was taken and no MRET has committed yet
//  double_trap         out  1   sticky: a trap was taken while in_handler=1
//  trap_count          out  CNT_W  traps taken (port present only with TRAP_CNT_EN)
// BEHAVIOUR
//  Reset values (at any clk edge with reset=1):
//  - FSM goes to RUN.
//  - pc_redirect, flush, busy, in_handler, double_trap = 0.
//  - pc_target = 0; flush counter = 0; trap_count = 0.
//  - Reset mid-FLUSH aborts the flush immediately; no residual strobes.
//  FSM state RUN:
//  - Trap: sampled initiate_exception=1 -> next cycle pc_redirect=1, pc_target={csr_mtvec[31:2],2'b00}, flush=1, go FLUSH.
//    Also sets in_handler=1. If in_handler was already 1, sets double_trap=1.
//  - MRET: sampled XB_mret=1 && XB_bubble=0 && initiate_exception=0 -> next cycle pc_redirect=1, pc_target={csr_mepc[31:2],2'b00}, flush=1, go FLUSH.
//    Clears in_handler.
//  - initiate_exception and XB_mret in the same cycle: the exception wins; in_handler is not cleared.
//  - XB_mret with XB_bubble=1 is ignored.
//  FSM state FLUSH:
//  - Counter loads FLUSH_CYCLES-1 on entry and decrements each cycle.
//  - flush=1 for exactly FLUSH_CYCLES consecutive cycles; at count 0, go RUN with flush=0.
//  - initiate_exception and XB_mret are ignored (they come from squashed younger instructions).
//  Output rules:
//  - pc_redirect is high for exactly 1 cycle per accepted event (the first FLUSH cycle).
//  - pc_target holds its value until the next accepted event.
//  - busy = (state != RUN). All outputs are registered.
//  - Latency is 1 cycle from the sampled request to pc_redirect.
//  - Minimum spacing between two accepted events is FLUSH_CYCLES+1 cycles.
//  - double_trap clears only on reset.
// CONFIGURATION
//  TRAP_CNT_EN defined:
//  - trap_count port exists and increments by 1 on each accepted trap.
//  - MRET does not increment it. It wraps modulo 2^CNT_W.
//  TRAP_CNT_EN undefined:
//  - No trap_count port and no counter logic; all other behaviour is identical.
// TESTING
//  1. Reset; csr_mtvec=0x00000004; pulse initiate_exception 1 cycle
//     -> next cycle pc_redirect=1, pc_target=0x4, flush=1 for 2 cycles, in_handler=1.
//  2. After test 1, csr_mepc=0x00000123, XB_mret=1, XB_bubble=0
//     -> pc_target=0x120, pc_redirect 1 cycle, in_handler=0, double_trap=0.
//  3. initiate_exception=1 and XB_mret=1 in the same cycle, csr_mtvec=0x100, csr_mepc=0x200
//     -> pc_target=0x100, in_handler=1.
//  4. Second trap while in_handler=1 -> double_trap=1; it stays 1 through a later MRET until reset.
//  5. initiate_exception held high for 5 cycles (FLUSH_CYCLES=2) -> exactly 2 pc_redirect pulses, 3 cycles apart.
//     XB_mret=1 with XB_bubble=1 -> no response.
//  6. Assert reset in the first FLUSH cycle -> next cycle flush=0, busy=0, trap_count=0 (TRAP_CNT_EN).
//     With TRAP_CNT_EN: 3 traps and 1 MRET -> trap_count=3.

Source files
------------

// File: rtl/trap_redirect_unit.sv
// trap_redirect_unit: turns CSR/EHU trap requests and committed MRETs into a
// one-cycle PC redirect followed by a counted flush of the FD/XB stages, and
// tracks whether the core is running inside a trap handler.
// Optional feature: define TRAP_CNT_EN to add the trap_count output.
module trap_redirect_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              initiate_exception,
  input  logic              XB_mret,
  input  logic              XB_bubble,
  input  logic [31:0]       csr_mtvec,
  input  logic [31:0]       csr_mepc,
  output logic              pc_redirect,
  output logic [31:0]       pc_target,
  output logic              flush,
  output logic              busy,
  output logic              in_handler,
  output logic              double_trap
`ifdef TRAP_CNT_EN
  ,
  output logic [CNT_W-1:0]  trap_count
`endif
);

  localparam int unsigned FCW = 4;

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  state_t         state;
  logic [FCW-1:0] flush_cnt;

  // Reject parameter values the flush counter cannot represent.
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
    $error("FLUSH_CYCLES must be in 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be at least 1");
  end

  // Redirect/flush sequencer with handler tracking; exception beats MRET.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      flush_cnt   <= '0;
      pc_redirect <= 1'b0;
      pc_target   <= 32'h0;
      flush       <= 1'b0;
      busy        <= 1'b0;
      in_handler  <= 1'b0;
      double_trap <= 1'b0;
    end else begin
      pc_redirect <= 1'b0;
      case (state)
        S_RUN: begin
          if (initiate_exception) begin
            state       <= S_FLUSH;
            flush_cnt   <= FCW'(FLUSH_CYCLES - 1);
            pc_redirect <= 1'b1;
            pc_target   <= {csr_mtvec[31:2], 2'b00};
            flush       <= 1'b1;
            busy        <= 1'b1;
            in_handler  <= 1'b1;
            if (in_handler) begin
              double_trap <= 1'b1;
            end
          end else if (XB_mret && !XB_bubble) begin
            state       <= S_FLUSH;
            flush_cnt   <= FCW'(FLUSH_CYCLES - 1);
            pc_redirect <= 1'b1;
            pc_target   <= {csr_mepc[31:2], 2'b00};
            flush       <= 1'b1;
            busy        <= 1'b1;
            in_handler  <= 1'b0;
          end
        end
        S_FLUSH: begin
          // Requests here belong to squashed younger instructions.
          if (flush_cnt == '0) begin
            state <= S_RUN;
            flush <= 1'b0;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FCW'(1);
          end
        end
        default: begin
          state <= S_RUN;
          flush <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRAP_CNT_EN
  // Count accepted traps only; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_count <= '0;
    end else if (state == S_RUN && initiate_exception) begin
      trap_count <= trap_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_trap_redirect_unit.sv
// Scoreboard bench for trap_redirect_unit: a driver issues directed and random
// stimulus and pushes expected redirects from a behavioural model; a monitor
// pops and compares whenever the DUT shows a redirect.
module tb_trap_redirect_unit;

  localparam int unsigned F = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        initiate_exception = 1'b0;
  logic        XB_mret = 1'b0;
  logic        XB_bubble = 1'b0;
  logic [31:0] csr_mtvec = 32'h0;
  logic [31:0] csr_mepc = 32'h0;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        flush;
  logic        busy;
  logic        in_handler;
  logic        double_trap;
`ifdef TRAP_CNT_EN
  logic [31:0] trap_count;
`endif

  trap_redirect_unit #(.FLUSH_CYCLES(F), .CNT_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .initiate_exception(initiate_exception),
    .XB_mret(XB_mret),
    .XB_bubble(XB_bubble),
    .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc),
    .pc_redirect(pc_redirect),
    .pc_target(pc_target),
    .flush(flush),
    .busy(busy),
    .in_handler(in_handler),
    .double_trap(double_trap)
`ifdef TRAP_CNT_EN
    ,
    .trap_count(trap_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    logic        ih;
    logic        dt;
    logic [31:0] tc;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state: deaf-cycle budget after each accepted event.
  int          m_deaf = 0;
  logic        m_ih = 1'b0;
  logic        m_dt = 1'b0;
  logic [31:0] m_tc = 32'h0;
  logic [31:0] m_last = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and predict the response to the coming edge.
  task automatic step(input logic rst, input logic ie, input logic mr, input logic bb,
                      input logic [31:0] tv, input logic [31:0] ep);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst;
    initiate_exception = ie;
    XB_mret = mr;
    XB_bubble = bb;
    csr_mtvec = tv;
    csr_mepc = ep;
    if (rst) begin
      m_deaf = 0;
      m_ih = 1'b0;
      m_dt = 1'b0;
      m_tc = 32'h0;
    end else if (m_deaf > 0) begin
      m_deaf--;
    end else if (ie) begin
      if (m_ih) m_dt = 1'b1;
      m_ih = 1'b1;
      m_tc = m_tc + 1;
      e.target = tv & 32'hFFFF_FFFC;
      e.ih = m_ih; e.dt = m_dt; e.tc = m_tc;
      q.push_back(e);
      m_deaf = F;
    end else if (mr && !bb) begin
      m_ih = 1'b0;
      e.target = ep & 32'hFFFF_FFFC;
      e.ih = m_ih; e.dt = m_dt; e.tc = m_tc;
      q.push_back(e);
      m_deaf = F;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: compares DUT outputs against scoreboard and model every cycle.
  initial begin : monitor
    logic rst_s;
    int   since;
    exp_t e;
    since = 1000;
    forever begin
      @(posedge clk);
      rst_s = reset;
      #1;
      if (rst_s) begin
        chk("reset_outputs", {pc_redirect, flush, busy, in_handler, double_trap, pc_target},
            64'h0);
`ifdef TRAP_CNT_EN
        chk("reset_trap_count", 64'(trap_count), 64'h0);
`endif
        q.delete();
        m_last = 32'h0;
        since = 1000;
      end else begin
        if (pc_redirect) begin
          chk("redirect_spacing", 64'(since >= int'(F)), 64'h1);
          since = 0;
          if (q.size() == 0) begin
            chk("unexpected_redirect", 64'h1, 64'h0);
          end else begin
            e = q.pop_front();
            m_last = e.target;
            chk("pc_target", 64'(pc_target), 64'(e.target));
            chk("redirect_in_handler", 64'(in_handler), 64'(e.ih));
            chk("redirect_double_trap", 64'(double_trap), 64'(e.dt));
`ifdef TRAP_CNT_EN
            chk("trap_count", 64'(trap_count), 64'(e.tc));
`endif
          end
        end else begin
          if (since < 1000) since++;
          if (q.size() != 0) begin
            chk("missing_redirect", 64'h0, 64'h1);
            void'(q.pop_front());
          end
          chk("pc_target_hold", 64'(pc_target), 64'(m_last));
        end
        chk("flush", 64'(flush), 64'(since < int'(F)));
        chk("busy", 64'(busy), 64'(since < int'(F)));
        chk("in_handler", 64'(in_handler), 64'(m_ih));
        chk("double_trap", 64'(double_trap), 64'(m_dt));
      end
    end
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin : driver
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    // trap to 0x4
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0);
    idle(4);
    // MRET to 0x123 -> 0x120
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0123);
    idle(4);
    // simultaneous trap and MRET: trap wins
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200);
    idle(4);
    // second trap while in handler, then MRET keeps double_trap
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0);
    idle(4);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0456);
    idle(4);
    // held request for 5 cycles
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000 + 32'(i), 32'h0);
    idle(4);
    // MRET in a bubble is ignored
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0888);
    idle(4);
    // reset during the first flush cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(4);
    // three traps and one MRET
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0077);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0048, 32'h0);
    idle(4);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           32'($urandom), 32'($urandom));
    end
    idle(6);
    chk("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
